// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush and
// multi-cycle mul/div occupancy sequencing, plus a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_muldiv,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        muldiv_busy,
  output logic        muldiv_done,
  output logic [15:0] stall_count
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_MULDIV = 2'd1;
  localparam logic [1:0] ST_ISSUE  = 2'd2;
  localparam logic [5:0] LOAD_VAL  = 6'(MULDIV_CYCLES - 1);

  logic [1:0] state_r;
  logic [1:0] state_next_s;
  logic [5:0] count_r;
  logic [5:0] count_next_s;
  logic       load_use_s;

  // Load-use hazard: ID reads a register that the load in EX is still producing.
  always_comb begin
    load_use_s = ex_mem_read && (ex_rd != 5'd0) &&
                 ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  end

  // Next-state and pipeline-control decode.
  always_comb begin
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b1;
    state_next_s = state_r;
    count_next_s = count_r;
    if (!reset) begin
      state_next_s = ST_RUN;
      count_next_s = 6'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (ex_branch_taken) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
          end else if (load_use_s) begin
            state_next_s = ST_RUN;
          end else if (id_is_muldiv) begin
            count_next_s = LOAD_VAL;
            // With the minimum occupancy there is no room for a MULDIV cycle.
            state_next_s = (MULDIV_CYCLES == 2) ? ST_ISSUE : ST_MULDIV;
          end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_bubble = 1'b0;
          end
        end
        ST_MULDIV: begin
          count_next_s = count_r - 6'd1;
          // Leave once the decremented count reaches 1 so ISSUE lands on the
          // MULDIV_CYCLES-th cycle after detection.
          if (count_r <= 6'd2) begin
            state_next_s = ST_ISSUE;
          end else begin
            state_next_s = ST_MULDIV;
          end
        end
        ST_ISSUE: begin
          pc_write     = 1'b1;
          ifid_write   = 1'b1;
          idex_bubble  = 1'b0;
          count_next_s = 6'd0;
          state_next_s = ST_RUN;
        end
        default: begin
          state_next_s = ST_RUN;
          count_next_s = 6'd0;
        end
      endcase
    end
  end

  // Sequence status, forced low while reset is held.
  always_comb begin
    muldiv_busy = reset && (state_r == ST_MULDIV);
    muldiv_done = reset && (state_r == ST_ISSUE);
  end

  // State and occupancy counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_RUN;
      count_r <= 6'd0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_count <= 16'd0;
    end else if (!pc_write && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end else begin
      stall_count <= stall_count;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random
// stimulus compared each cycle against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;

  localparam int N = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt, id_is_muldiv, ex_mem_read, ex_branch_taken;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_busy, muldiv_done;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;
  int md_wait  = 0;   // cycles remaining until the mul/div issues (0 = none pending)
  int stall_m  = 0;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.MULDIV_CYCLES(N)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_muldiv(id_is_muldiv), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
    .stall_count(stall_count)
  );

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_muldiv = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
  endtask

  // Wait to the falling edge, compare against the model, then advance the model.
  task automatic sample();
    logic       lu;
    logic [5:0] e;  // {pc_write, ifid_write, ifid_flush, idex_bubble, busy, done}
    @(negedge clock);
    lu = ex_mem_read && ex_rd != 5'd0 &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    if (!reset)                e = 6'b000100;
    else if (md_wait >= 2)     e = 6'b000110;
    else if (md_wait == 1)     e = 6'b110001;
    else if (ex_branch_taken)  e = 6'b111100;
    else if (lu || id_is_muldiv) e = 6'b000100;
    else                       e = 6'b110000;
    check("outputs", {11'd0, pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_busy, muldiv_done},
          {11'd0, e});
    check("stall_count", {1'b0, stall_count}, 17'(stall_m));
    if (!reset) begin
      stall_m = 0;
      md_wait = 0;
    end else begin
      if (!e[5] && stall_m < 65535) stall_m++;
      if (md_wait > 0) md_wait--;
      else if (!ex_branch_taken && !lu && id_is_muldiv) md_wait = N - 1;
    end
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    sample(); advance();
    sample(); advance();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    #1;
    do_reset();

    // Reset state and idle RUN
    sample();
    check("idle_pc_write", {16'd0, pc_write}, 17'd1);
    check("idle_stall", {1'b0, stall_count}, 17'd0);
    advance();

    // Load-use on rs
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    sample();
    check("lu_pc_write", {16'd0, pc_write}, 17'd0);
    check("lu_ifid_write", {16'd0, ifid_write}, 17'd0);
    check("lu_bubble", {16'd0, idex_bubble}, 17'd1);
    check("lu_stall_before", {1'b0, stall_count}, 17'd0);
    advance();
    clear_inputs();
    sample();
    check("lu_release_pc", {16'd0, pc_write}, 17'd1);
    check("lu_stall_after", {1'b0, stall_count}, 17'd1);
    advance();

    // ex_rd == 0 never stalls
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    sample();
    check("r0_pc_write", {16'd0, pc_write}, 17'd1);
    check("r0_bubble", {16'd0, idex_bubble}, 17'd0);
    advance();

    // Branch beats load-use
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1; ex_branch_taken = 1'b1;
    id_uses_rt = 1'b0;
    sample();
    check("br_flush", {16'd0, ifid_flush}, 17'd1);
    check("br_bubble", {16'd0, idex_bubble}, 17'd1);
    check("br_pc_write", {16'd0, pc_write}, 17'd1);
    advance();
    clear_inputs();
    sample();
    check("br_stall_unchanged", {1'b0, stall_count}, 17'd1);
    advance();

    // Mul/div sequence with MULDIV_CYCLES=4
    id_is_muldiv = 1'b1;
    sample();
    check("md_T_pc", {16'd0, pc_write}, 17'd0);
    advance();
    clear_inputs();
    sample();
    check("md_T1_busy", {16'd0, muldiv_busy}, 17'd1);
    advance();
    sample();
    check("md_T2_busy", {16'd0, muldiv_busy}, 17'd1);
    advance();
    sample();
    check("md_T3_done", {16'd0, muldiv_done}, 17'd1);
    check("md_T3_pc", {16'd0, pc_write}, 17'd1);
    check("md_T3_busy", {16'd0, muldiv_busy}, 17'd0);
    check("md_stall", {1'b0, stall_count}, 17'd4);
    advance();
    sample();
    check("md_after_done", {16'd0, muldiv_done}, 17'd0);
    advance();

    // Reset during the second MULDIV cycle aborts the sequence
    id_is_muldiv = 1'b1;
    sample(); advance();
    clear_inputs();
    sample(); advance();
    reset = 1'b0;
    sample();
    check("abort_busy_in_reset", {16'd0, muldiv_busy}, 17'd0);
    check("abort_bubble_in_reset", {16'd0, idex_bubble}, 17'd1);
    advance();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("abort_no_done", {16'd0, muldiv_done}, 17'd0);
      check("abort_pc", {16'd0, pc_write}, 17'd1);
      advance();
    end
    check("abort_stall", {1'b0, stall_count}, 17'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset           = ($urandom_range(0, 59) != 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      id_is_muldiv    = ($urandom_range(0, 5) == 0);
      sample();
      advance();
    end

    // Saturation under a permanent load-use hazard
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      sample();
      advance();
    end
    sample();
    check("stall_saturated", {1'b0, stall_count}, 17'h0FFFF);
    advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
